// File: rtl/mdpad_pkg.sv
// mdpad_pkg: shared definitions for the Mega Drive DB9 pad scanner.
//   - button bit positions inside a 12-bit player word
//   - scanner state enum
//   - select-phase numbers with special meaning
package mdpad_pkg;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_Z     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_X     = 10;
    localparam int BTN_MODE  = 11;

    typedef enum logic {IDLE, SCAN} state_t;

    // Third low select pulse: a 6-button pad pulls U/D/L/R low here.
    localparam logic [2:0] PH_ID   = 3'd5;
    // Following high pulse: a 6-button pad reports Z/Y/X/Mode on the direction pins.
    localparam logic [2:0] PH_EXT  = 3'd6;
    localparam logic [2:0] PH_LAST = 3'd7;

endpackage

// File: rtl/mdpad_decode.sv
// mdpad_decode: phase-to-field capture and shadow registers for the player
// currently being scanned. One instance serves all players; every field is
// overwritten during each player's eight phases, so no clear is needed.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   sample        last clock of the current phase
//   phase         current select phase 0..7
//   pad_in        raw active-low pins {C/Start, B/A, Right, Left, Down, Up}
//   shadow_word   captured active-high {Mode,X,Y,Z,Start,C,B,A,U,D,L,R}
//   shadow_six    6-button identification captured at PH_ID
module mdpad_decode
    import mdpad_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample,
    input  logic [2:0]  phase,
    input  logic [5:0]  pad_in,
    output logic [11:0] shadow_word,
    output logic        shadow_six
);

    logic [5:0]  pin;
    logic [11:0] word_q, word_d;
    logic        six_q, six_d;

    assign pin = ~pad_in;

    always_comb begin
        word_d = word_q;
        six_d  = six_q;
        if (sample) begin
            case (phase)
                3'd0: begin
                    word_d[BTN_U] = pin[0];
                    word_d[BTN_D] = pin[1];
                    word_d[BTN_L] = pin[2];
                    word_d[BTN_R] = pin[3];
                    word_d[BTN_B] = pin[4];
                    word_d[BTN_C] = pin[5];
                end
                3'd1: begin
                    word_d[BTN_A]     = pin[4];
                    word_d[BTN_START] = pin[5];
                end
                PH_ID: six_d = &pin[3:0];
                PH_EXT: begin
                    // Extended buttons are only meaningful on an identified 6-button pad.
                    word_d[BTN_Z]    = pin[0] & six_q;
                    word_d[BTN_Y]    = pin[1] & six_q;
                    word_d[BTN_X]    = pin[2] & six_q;
                    word_d[BTN_MODE] = pin[3] & six_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            six_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            six_q  <= six_d;
        end
    end

    assign shadow_word = word_q;
    assign shadow_six  = six_q;

endmodule

// File: rtl/mdpad_scan.sv
// mdpad_scan: multi-port Sega Mega Drive DB9 pad scanner.
// Rests IDLE_CYCLES clocks, then walks each player through eight select
// phases of PHASE_CYCLES clocks and commits the decoded word atomically.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   enable        scanning allowed; sampled at the idle terminal count
//   pad_in        shared raw pins, active-low
//   pad_sel       Mega Drive SELECT pin
//   pad_split     index of the addressed player
//   joy_out       12 bits per player, active-high, player 0 in [11:0]
//   six_btn       per-player 6-button identification
//   frame_done    one-cycle pulse the cycle after the last player commits
// Build option: define MDPAD_DEBOUNCE_EN to commit a player's word only when
// two consecutive scans agree on {six, word}.
module mdpad_scan
    import mdpad_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned PHASE_CYCLES = 400,
    parameter int unsigned IDLE_CYCLES  = 80000,
    parameter int unsigned SPLIT_W      = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [5:0]               pad_in,
    output logic                     pad_sel,
    output logic [SPLIT_W-1:0]       pad_split,
    output logic [12*NUM_PLAYERS-1:0] joy_out,
    output logic [NUM_PLAYERS-1:0]   six_btn,
    output logic                     frame_done
);

    localparam int unsigned PHC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned IDC_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned PL_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    localparam logic [PHC_W-1:0] PHC_LAST  = PHC_W'(PHASE_CYCLES - 1);
    localparam logic [IDC_W-1:0] IDC_LAST  = IDC_W'(IDLE_CYCLES - 1);
    localparam logic [PL_W-1:0]  PL_LAST   = PL_W'(NUM_PLAYERS - 1);

    state_t                      state_q, state_d;
    logic [IDC_W-1:0]            idle_cnt_q, idle_cnt_d;
    logic [PHC_W-1:0]            phase_cnt_q, phase_cnt_d;
    logic [2:0]                  phase_q, phase_d;
    logic [PL_W-1:0]             player_q, player_d;
    logic [12*NUM_PLAYERS-1:0]   joy_q, joy_d;
    logic [NUM_PLAYERS-1:0]      six_q, six_d;
    logic                        done_pend_q, done_pend_d;
    logic                        frame_done_q, frame_done_d;
    logic                        sample;
    logic                        commit;
    logic [11:0]                 shadow_word;
    logic                        shadow_six;
`ifdef MDPAD_DEBOUNCE_EN
    logic [13*NUM_PLAYERS-1:0]   cand_q, cand_d;
`endif

    mdpad_decode u_decode (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample      (sample),
        .phase       (phase_q),
        .pad_in      (pad_in),
        .shadow_word (shadow_word),
        .shadow_six  (shadow_six)
    );

    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        phase_cnt_d  = phase_cnt_q;
        phase_d      = phase_q;
        player_d     = player_q;
        joy_d        = joy_q;
        six_d        = six_q;
        done_pend_d  = 1'b0;
        frame_done_d = done_pend_q;
        sample       = 1'b0;
        commit       = 1'b0;
`ifdef MDPAD_DEBOUNCE_EN
        cand_d       = cand_q;
`endif

        case (state_q)
            IDLE: begin
                if (idle_cnt_q == IDC_LAST) begin
                    idle_cnt_d = '0;
                    if (enable) begin
                        state_d     = SCAN;
                        player_d    = '0;
                        phase_d     = '0;
                        phase_cnt_d = '0;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            SCAN: begin
                if (phase_cnt_q == PHC_LAST) begin
                    sample      = 1'b1;
                    phase_cnt_d = '0;
                    phase_d     = phase_q + 3'd1;
                    if (phase_q == PH_LAST) begin
                        commit = 1'b1;
                        if (player_q == PL_LAST) begin
                            state_d     = IDLE;
                            player_d    = '0;
                            done_pend_d = 1'b1;
                        end else begin
                            player_d = player_q + 1'b1;
                        end
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
`ifdef MDPAD_DEBOUNCE_EN
            if (cand_q[13*player_q +: 13] == {shadow_six, shadow_word}) begin
                joy_d[12*player_q +: 12] = shadow_word;
                six_d[player_q]          = shadow_six;
            end
            cand_d[13*player_q +: 13] = {shadow_six, shadow_word};
`else
            joy_d[12*player_q +: 12] = shadow_word;
            six_d[player_q]          = shadow_six;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            phase_cnt_q  <= '0;
            phase_q      <= '0;
            player_q     <= '0;
            joy_q        <= '0;
            six_q        <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            phase_q      <= phase_d;
            player_q     <= player_d;
            joy_q        <= joy_d;
            six_q        <= six_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef MDPAD_DEBOUNCE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
        end else begin
            cand_q <= cand_d;
        end
    end
`endif

    assign pad_sel    = (state_q == SCAN) ? ~phase_q[0] : 1'b1;
    assign pad_split  = SPLIT_W'(player_q);
    assign joy_out    = joy_q;
    assign six_btn    = six_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mdpad_scan.sv
// Testbench for mdpad_scan: behavioural 3/6-button pad models on the shared
// bus, expected frames pushed to a scoreboard queue and compared at frame_done.
module tb_mdpad_scan;
    import mdpad_pkg::*;

    localparam int unsigned NP = 2;
    localparam int unsigned PC = 4;
    localparam int unsigned IC = 16;
    localparam int FRAME = NP * 8 * PC + IC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [5:0]  pad_in;
    logic        pad_sel;
    logic [1:0]  pad_split;
    logic [23:0] joy_out;
    logic [1:0]  six_btn;
    logic        frame_done;

    // Pad configuration per player
    logic [1:0]  pres;
    logic [1:0]  is6;
    logic [23:0] btns;

    // Select falling-edge counter of the addressed pad
    int          lows;
    logic        sel_prev;
    logic [1:0]  split_prev;

    int          checks;
    int          errors;
    logic [25:0] exp_q[$];

    logic [11:0] m_joy [2];
    logic [1:0]  m_six;
    logic [12:0] m_cand [2];

    always #5 clk = ~clk;

    mdpad_scan #(
        .NUM_PLAYERS  (NP),
        .PHASE_CYCLES (PC),
        .IDLE_CYCLES  (IC),
        .SPLIT_W      (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .pad_in     (pad_in),
        .pad_sel    (pad_sel),
        .pad_split  (pad_split),
        .joy_out    (joy_out),
        .six_btn    (six_btn),
        .frame_done (frame_done)
    );

    function automatic logic [5:0] pad_drive(input logic present, input logic six,
                                             input logic [11:0] b, input logic sel,
                                             input int n);
        logic [5:0] p;
        if (!present) return 6'h3F;
        if (sel) begin
            if (six && n == 3) p = {b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
            else               p = {b[BTN_C], b[BTN_B], b[BTN_R], b[BTN_L], b[BTN_D], b[BTN_U]};
        end else begin
            if (six && n == 3) p = {b[BTN_START], b[BTN_A], 4'hF};
            else               p = {b[BTN_START], b[BTN_A], 2'b11, b[BTN_D], b[BTN_U]};
        end
        return ~p;
    endfunction

    assign pad_in = pad_drive(pres[pad_split[0]], is6[pad_split[0]],
                              btns[12*pad_split[0] +: 12], pad_sel, lows);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lows       <= 0;
            sel_prev   <= 1'b1;
            split_prev <= 2'd0;
        end else begin
            sel_prev   <= pad_sel;
            split_prev <= pad_split;
            if (pad_split != split_prev)      lows <= 0;
            else if (sel_prev && !pad_sel)    lows <= lows + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] raw_word(input int p);
        logic [11:0] b;
        if (!pres[p]) return 13'd0;
        b = btns[12*p +: 12];
        if (!is6[p]) b[11:8] = 4'h0;
        return {is6[p], b};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_joy[p]  = 12'h0;
            m_cand[p] = 13'h0;
        end
        m_six = 2'b00;
    endtask

    function automatic logic [25:0] model_out();
        return {m_six, m_joy[1], m_joy[0]};
    endfunction

    task automatic model_scan();
        logic [12:0] r;
        for (int p = 0; p < 2; p++) begin
            r = raw_word(p);
`ifdef MDPAD_DEBOUNCE_EN
            if (r == m_cand[p]) begin
                m_joy[p] = r[11:0];
                m_six[p] = r[12];
            end
            m_cand[p] = r;
`else
            m_joy[p] = r[11:0];
            m_six[p] = r[12];
`endif
        end
        exp_q.push_back(model_out());
    endtask

    task automatic wait_frame(input int limit, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (frame_done) seen = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input bit chk_period);
        int          cyc;
        bit          seen;
        logic [25:0] exp;
        model_scan();
        wait_frame(4 * FRAME, cyc, seen);
        check({tag, " frame_done"}, 32'(seen), 32'd1);
        if (chk_period) check({tag, " period"}, 32'(cyc), 32'(FRAME));
        exp = exp_q.pop_front();
        check(tag, {6'd0, six_btn, joy_out}, {6'd0, exp});
    endtask

    // With debounce a new value needs two agreeing scans before it is visible.
    task automatic run_settled(input string tag, input bit chk_period);
`ifdef MDPAD_DEBOUNCE_EN
        run_frame({tag, " settle"}, chk_period);
        run_frame(tag, 1'b1);
`else
        run_frame(tag, chk_period);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " joy_out"},    {8'd0, joy_out},    32'd0);
        check({tag, " six_btn"},    {30'd0, six_btn},   32'd0);
        check({tag, " pad_sel"},    {31'd0, pad_sel},   32'd1);
        check({tag, " pad_split"},  {30'd0, pad_split}, 32'd0);
        check({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          done_e;
        int          k;
        int          ph;
        int          cyc;
        bit          seen;
        logic        exp_sel;
        logic [1:0]  exp_split;
        logic [11:0] b;
        logic [25:0] exp;

        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        enable  = 1'b1;
        pres    = 2'b00;
        is6     = 2'b00;
        btns    = 24'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Unplugged pads; check select/split timeline and first frame_done edge.
        model_scan();
        reset_n = 1'b1;
        done_e  = 0;
        for (int e = 1; e <= 200 && done_e == 0; e++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                done_e = e;
            end else begin
                exp_sel   = 1'b1;
                exp_split = 2'd0;
                if (e >= int'(IC) && e < int'(IC) + 64) begin
                    k         = e - int'(IC);
                    ph        = (k / int'(PC)) % 8;
                    exp_sel   = (ph % 2) == 0;
                    exp_split = 2'(k / (8 * int'(PC)));
                end
                check("pad_sel timeline", {31'd0, pad_sel}, {31'd0, exp_sel});
                check("pad_split timeline", {30'd0, pad_split}, {30'd0, exp_split});
            end
        end
        check("first frame_done cycle", 32'(done_e), 32'(FRAME + 1));
        exp = exp_q.pop_front();
        check("unplugged", {6'd0, six_btn, joy_out}, {6'd0, exp});
        check("unplugged literal", {6'd0, six_btn, joy_out}, 32'd0);
        @(posedge clk);
        #1;
        check("frame_done width", {31'd0, frame_done}, 32'd0);

        // 3-button A+Right on player 0, 6-button Mode+Start on player 1.
        pres = 2'b11;
        is6  = 2'b10;
        btns = {12'h880, 12'h011};
        run_settled("mixed pads", 1'b0);
        check("mixed joy literal", {8'd0, joy_out}, 32'h880011);
        check("mixed six literal", {30'd0, six_btn}, 32'h2);

        // 3-button pads: Right seen at the extended phase must not become Mode.
        is6  = 2'b00;
        btns = {12'h401, 12'h001};
        run_settled("six gating", 1'b1);
        check("six gating literal", {8'd0, joy_out}, 32'h001001);
        check("six gating six", {30'd0, six_btn}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            pres = 2'($urandom_range(1, 3));
            is6  = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                b = 12'($urandom);
                if (!is6[p] && b[BTN_U]) b[BTN_D] = 1'b0;
                btns[12*p +: 12] = b;
            end
            run_frame("random", 1'b1);
        end

        // enable dropped mid-scan: the scan finishes, then scanning stops.
        pres = 2'b11;
        is6  = 2'b01;
        btns = {12'h021, 12'h90C};
        model_scan();
        cyc = 0;
        while (pad_split != 2'd1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach player 1", {30'd0, pad_split}, 32'd1);
        enable = 1'b0;
        wait_frame(200, cyc, seen);
        check("disabled scan completes", 32'(seen), 32'd1);
        exp = exp_q.pop_front();
        check("disabled commit", {6'd0, six_btn, joy_out}, {6'd0, exp});
        btns = {12'h0F0, 12'h00F};
        wait_frame(5 * FRAME, cyc, seen);
        check("no scan while disabled", 32'(seen), 32'd0);
        check("hold while disabled", {6'd0, six_btn, joy_out}, {6'd0, model_out()});
        enable = 1'b1;
        run_frame("re-enable", 1'b0);

        // Asynchronous reset at phase 3 of player 1.
        btns = {12'hC12, 12'h844};
        is6  = 2'b11;
        cyc  = 0;
        while (!(pad_split == 2'd1 && pad_sel == 1'b0 && lows == 2) && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach p1 phase 3", 32'(cyc < 400), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("mid-scan reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_scan();
        wait_frame(200, cyc, seen);
        check("restart frame_done cycle", 32'(cyc), 32'(FRAME + 1));
        exp = exp_q.pop_front();
        check("restart frame", {6'd0, six_btn, joy_out}, {6'd0, exp});

`ifdef MDPAD_DEBOUNCE_EN
        pres = 2'b11;
        is6  = 2'b00;
        btns = {12'h000, 12'h010};
        run_settled("deb base", 1'b1);
        check("deb base literal", {20'd0, joy_out[11:0]}, 32'h010);
        btns[11:0] = 12'h030;
        run_frame("deb glitch", 1'b1);
        check("deb glitch held", {20'd0, joy_out[11:0]}, 32'h010);
        btns[11:0] = 12'h010;
        run_frame("deb glitch gone", 1'b1);
        check("deb glitch gone literal", {20'd0, joy_out[11:0]}, 32'h010);
        btns[11:0] = 12'h030;
        run_frame("deb first", 1'b1);
        check("deb first held", {20'd0, joy_out[11:0]}, 32'h010);
        run_frame("deb second", 1'b1);
        check("deb second commit", {20'd0, joy_out[11:0]}, 32'h030);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
